// File: rtl/io_port_bridge.sv
// io_port_bridge: device-side bridge for the processor IN/OUT ports.
// Optional macro IO_TX_COUNT_EN adds the tx_count handshake counter port.
module io_port_bridge #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cpu_out_data,
    input  logic              cpu_out_we,
    output logic [DATA_W-1:0] cpu_in_data,
    input  logic              cpu_in_rd,
    output logic              cpu_stall,
    output logic              in_valid,
    output logic              ovf_sticky,
    output logic [DATA_W-1:0] ext_tx_data,
    output logic              ext_tx_valid,
    input  logic              ext_tx_ready,
    input  logic [DATA_W-1:0] ext_rx_data,
    input  logic              ext_rx_valid,
    output logic              ext_rx_ready
`ifdef IO_TX_COUNT_EN
    ,
    output logic [15:0]       tx_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        EMPTY,
        FULL
    } rx_state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    rx_state_t state_q;
    rx_state_t state_d;
    logic      capture;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
    assign pop  = !fifo_empty && ext_tx_ready;
    assign push = cpu_out_we && (!fifo_full || pop);

    assign cpu_stall    = fifo_full;
    assign ext_tx_valid = !fifo_empty;
    // Gate the head so the bus reads zero when nothing is queued.
    assign ext_tx_data  = fifo_empty ? '0 : mem[rd_ptr];

    // FIFO storage: write the pushed word at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cpu_out_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for an OUT word lost to a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (cpu_out_we && fifo_full && !pop) begin
            ovf_sticky <= 1'b1;
        end
    end

    // RX state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // RX next state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        ext_rx_ready = 1'b0;
        in_valid     = 1'b0;
        unique case (state_q)
            EMPTY: begin
                ext_rx_ready = 1'b1;
                if (ext_rx_valid) begin
                    capture = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                in_valid = 1'b1;
                if (cpu_in_rd) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Holding register keeps the last word after it has been read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_in_data <= '0;
        end else if (capture) begin
            cpu_in_data <= ext_rx_data;
        end
    end

`ifdef IO_TX_COUNT_EN
    // Completed TX handshakes, wrapping at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_count <= '0;
        end else if (pop) begin
            tx_count <= tx_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_io_port_bridge.sv
// tb_io_port_bridge: table vectors plus a TX scoreboard queue and RX model.
// Build with IO_TX_COUNT_EN defined to also exercise the tx_count wrap.
module tb_io_port_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_out_data;
    logic        cpu_out_we;
    logic [15:0] cpu_in_data;
    logic        cpu_in_rd;
    logic        cpu_stall;
    logic        in_valid;
    logic        ovf_sticky;
    logic [15:0] ext_tx_data;
    logic        ext_tx_valid;
    logic        ext_tx_ready;
    logic [15:0] ext_rx_data;
    logic        ext_rx_valid;
    logic        ext_rx_ready;
`ifdef IO_TX_COUNT_EN
    logic [15:0] tx_count;
`endif

    io_port_bridge #(.DATA_W(16), .DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_out_data (cpu_out_data),
        .cpu_out_we   (cpu_out_we),
        .cpu_in_data  (cpu_in_data),
        .cpu_in_rd    (cpu_in_rd),
        .cpu_stall    (cpu_stall),
        .in_valid     (in_valid),
        .ovf_sticky   (ovf_sticky),
        .ext_tx_data  (ext_tx_data),
        .ext_tx_valid (ext_tx_valid),
        .ext_tx_ready (ext_tx_ready),
        .ext_rx_data  (ext_rx_data),
        .ext_rx_valid (ext_rx_valid),
        .ext_rx_ready (ext_rx_ready)
`ifdef IO_TX_COUNT_EN
        ,
        .tx_count     (tx_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] d;
        logic        rdy;
        logic        rxv;
        logic [15:0] rxd;
        logic        rd;
        logic        e_txv;
        logic [15:0] e_txd;
        logic        e_rxrdy;
        logic        e_inv;
        logic [15:0] e_ind;
    } vec_t;

    vec_t vecs [12];

    int checks = 0;
    int failures = 0;
    int popped = 0;

    logic [15:0] q [$];
    logic        ovf_m;
    logic        rx_full_m;
    logic [15:0] rx_data_m;

    function automatic vec_t mk(
        input logic we, input logic [15:0] d, input logic rdy,
        input logic rxv, input logic [15:0] rxd, input logic rd,
        input logic e_txv, input logic [15:0] e_txd,
        input logic e_rxrdy, input logic e_inv,
        input logic [15:0] e_ind);
        vec_t v;
        v.we = we; v.d = d; v.rdy = rdy;
        v.rxv = rxv; v.rxd = rxd; v.rd = rd;
        v.e_txv = e_txv; v.e_txd = e_txd;
        v.e_rxrdy = e_rxrdy; v.e_inv = e_inv; v.e_ind = e_ind;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovf_m = 1'b0;
        rx_full_m = 1'b0;
        rx_data_m = 16'h0;
    endtask

    // Drive one cycle of inputs and compare against the model.
    task automatic drive_check(
        input logic we, input logic [15:0] d, input logic rdy,
        input logic rxv, input logic [15:0] rxd, input logic rd);
        cpu_out_we = we;
        cpu_out_data = d;
        ext_tx_ready = rdy;
        ext_rx_valid = rxv;
        ext_rx_data = rxd;
        cpu_in_rd = rd;
        #2;
        chk("tx_valid", 32'(ext_tx_valid), 32'(q.size() != 0));
        chk("stall", 32'(cpu_stall), 32'(q.size() == 8));
        chk("ovf", 32'(ovf_sticky), 32'(ovf_m));
        chk("rx_ready", 32'(ext_rx_ready), 32'(!rx_full_m));
        chk("in_valid", 32'(in_valid), 32'(rx_full_m));
        chk("in_data", 32'(cpu_in_data), 32'(rx_data_m));
        if (q.size() != 0) begin
            chk("tx_data", 32'(ext_tx_data), 32'(q[0]));
        end
    endtask

    // Update the model with the driven inputs, then cross the edge.
    task automatic advance();
        logic pop_m;
        logic push_m;
        pop_m = (q.size() != 0) && ext_tx_ready;
        push_m = cpu_out_we && ((q.size() < 8) || pop_m);
        if (cpu_out_we && (q.size() == 8) && !pop_m) ovf_m = 1'b1;
        if (pop_m) begin
            void'(q.pop_front());
            popped++;
        end
        if (push_m) q.push_back(cpu_out_data);
        if (!rx_full_m && ext_rx_valid) begin
            rx_full_m = 1'b1;
            rx_data_m = ext_rx_data;
        end else if (rx_full_m && cpu_in_rd) begin
            rx_full_m = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(
        input logic we, input logic [15:0] d, input logic rdy,
        input logic rxv, input logic [15:0] rxd, input logic rd);
        drive_check(we, d, rdy, rxv, rxd, rd);
        advance();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cpu_out_we = 1'b0;
        ext_tx_ready = 1'b0;
        ext_rx_valid = 1'b0;
        cpu_in_rd = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cpu_out_data = '0;
        cpu_out_we = 1'b0;
        cpu_in_rd = 1'b0;
        ext_tx_ready = 1'b0;
        ext_rx_data = '0;
        ext_rx_valid = 1'b0;
        model_reset();

        vecs[0]  = mk(1, 16'h1234, 1, 0, 16'h0, 0,
                      0, 16'h0, 1, 0, 16'h0);
        vecs[1]  = mk(0, 16'h0, 1, 0, 16'h0, 0,
                      1, 16'h1234, 1, 0, 16'h0);
        vecs[2]  = mk(0, 16'h0, 1, 1, 16'hBEEF, 0,
                      0, 16'h0, 1, 0, 16'h0);
        vecs[3]  = mk(0, 16'h0, 1, 0, 16'h0, 0,
                      0, 16'h0, 0, 1, 16'hBEEF);
        vecs[4]  = mk(0, 16'h0, 1, 0, 16'h0, 1,
                      0, 16'h0, 0, 1, 16'hBEEF);
        vecs[5]  = mk(0, 16'h0, 1, 0, 16'h0, 0,
                      0, 16'h0, 1, 0, 16'hBEEF);
        vecs[6]  = mk(0, 16'h0, 1, 0, 16'h0, 1,
                      0, 16'h0, 1, 0, 16'hBEEF);
        vecs[7]  = mk(1, 16'h0001, 0, 1, 16'h5A5A, 0,
                      0, 16'h0, 1, 0, 16'hBEEF);
        vecs[8]  = mk(1, 16'h0002, 0, 1, 16'h1111, 0,
                      1, 16'h0001, 0, 1, 16'h5A5A);
        vecs[9]  = mk(0, 16'h0, 1, 0, 16'h0, 1,
                      1, 16'h0001, 0, 1, 16'h5A5A);
        vecs[10] = mk(0, 16'h0, 1, 0, 16'h0, 0,
                      1, 16'h0002, 1, 0, 16'h5A5A);
        vecs[11] = mk(0, 16'h0, 1, 0, 16'h0, 0,
                      0, 16'h0, 1, 0, 16'h5A5A);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(ext_tx_valid), 32'd0);
        chk("rst_tx_data", 32'(ext_tx_data), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_ovf", 32'(ovf_sticky), 32'd0);
        chk("rst_in_valid", 32'(in_valid), 32'd0);
        chk("rst_in_data", 32'(cpu_in_data), 32'd0);
        chk("rst_rx_ready", 32'(ext_rx_ready), 32'd1);
`ifdef IO_TX_COUNT_EN
        chk("rst_tx_count", 32'(tx_count), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive_check(vecs[i].we, vecs[i].d, vecs[i].rdy,
                        vecs[i].rxv, vecs[i].rxd, vecs[i].rd);
            chk($sformatf("vec%0d_txv", i), 32'(ext_tx_valid),
                32'(vecs[i].e_txv));
            chk($sformatf("vec%0d_txd", i), 32'(ext_tx_data),
                32'(vecs[i].e_txd));
            chk($sformatf("vec%0d_rxrdy", i), 32'(ext_rx_ready),
                32'(vecs[i].e_rxrdy));
            chk($sformatf("vec%0d_inv", i), 32'(in_valid),
                32'(vecs[i].e_inv));
            chk($sformatf("vec%0d_ind", i), 32'(cpu_in_data),
                32'(vecs[i].e_ind));
            advance();
        end

        // Full FIFO with simultaneous push and pop.
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            cycle(1, 16'h0100 + 16'(i), 0, 0, 16'h0, 0);
        end
        cycle(1, 16'hCAFE, 1, 0, 16'h0, 0);
        drive_check(0, 16'h0, 0, 0, 16'h0, 0);
        chk("pushpop_stall", 32'(cpu_stall), 32'd1);
        chk("pushpop_ovf", 32'(ovf_sticky), 32'd0);
        advance();

        // Overflow on the ninth OUT, then drain in order.
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            cycle(1, 16'h0200 + 16'(i), 0, 0, 16'h0, 0);
        end
        cycle(1, 16'hDEAD, 0, 0, 16'h0, 0);
        drive_check(0, 16'h0, 0, 0, 16'h0, 0);
        chk("ovf_set", 32'(ovf_sticky), 32'd1);
        advance();
        popped = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(0, 16'h0, 1, 0, 16'h0, 0);
        end
        chk("drain_count", 32'(popped), 32'd8);
        chk("drain_empty", 32'(ext_tx_valid), 32'd0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 16'h0300 + 16'(i), 0, 0, 16'h0, 0);
        end
        cycle(0, 16'h0, 0, 1, 16'h7777, 0);
        cycle(0, 16'h0, 0, 0, 16'h0, 0);
        rst = 1'b1;
        #2;
        chk("mid_tx_valid", 32'(ext_tx_valid), 32'd0);
        chk("mid_tx_data", 32'(ext_tx_data), 32'd0);
        chk("mid_stall", 32'(cpu_stall), 32'd0);
        chk("mid_ovf", 32'(ovf_sticky), 32'd0);
        chk("mid_in_valid", 32'(in_valid), 32'd0);
        chk("mid_in_data", 32'(cpu_in_data), 32'd0);
        chk("mid_rx_ready", 32'(ext_rx_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(0, 16'h0, 1, 0, 16'h0, 0);
        cycle(0, 16'h0, 1, 0, 16'h0, 0);

`ifdef IO_TX_COUNT_EN
        reset_dut();
        ext_tx_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            cpu_out_we = 1'b1;
            cpu_out_data = 16'(i);
            @(posedge clk);
            #1;
        end
        cpu_out_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("tx_count_wrap", 32'(tx_count), 32'd1);
        chk("tx_count_empty", 32'(ext_tx_valid), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
